uart_tx_serializer: RTL and testbench

- Serializes one 8-bit character plus its precomputed parity bit onto the UART TX line as a start/data/parity/stop frame.
- Sits directly downstream of the transmit parity generator: consumes its data byte and parity bit.
- Upstream logic starts a frame with a start/busy/done handshake.
- Bit timing comes from an internal clocks-per-bit counter.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_serializer.sv | 123 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, data width and parity-type constants.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Parity sense; resolved by the parity generator, carried here for reuse.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// While clear is high the counter sits at 0 and no tick is produced.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Free-running bit counter, wraps to 0 at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || (count == TERM)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_tick = !clear && (count == TERM);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Frame inputs are captured when the frame is accepted.
// Handshake: tx_start is a request sampled only in IDLE; tx_busy is high from
// the accepting edge until the frame ends, and tx_done pulses for one cycle as
// tx_busy falls. A request seen in the tx_done cycle is accepted immediately.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_start,
  input  logic [UART_DATA_W-1:0] data_in,
  input  logic                   parity_in,
  input  logic                   parity_en,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done,
  output tx_state_t              fsm_state
);

  tx_state_t              state;
  logic [UART_DATA_W-1:0] shadow_data;
  logic                   shadow_par;
  logic                   shadow_par_en;
  logic [2:0]             bit_idx;
  logic                   stop_idx;
  logic                   stop_last;
  logic                   bit_tick;

  // The bit counter only runs while a frame is in flight.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_IDLE),
    .bit_tick (bit_tick)
  );

  assign stop_last = (STOP_BITS == 1) || stop_idx;
  assign fsm_state = state;

  // Frame sequencer; tx is registered and updated at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      tx            <= 1'b1;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
      shadow_data   <= '0;
      shadow_par    <= 1'b0;
      shadow_par_en <= 1'b0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shadow_data   <= data_in;
            shadow_par    <= parity_in;
            shadow_par_en <= parity_en;
            state         <= ST_START;
            tx            <= 1'b0;
            tx_busy       <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shadow_data[0];
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              if (shadow_par_en) begin
                state <= ST_PARITY;
                tx    <= shadow_par;
              end else begin
                state    <= ST_STOP;
                tx       <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shadow_data[bit_idx + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (stop_last) begin
              state   <= ST_IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: one instance with 1 stop bit, one with 2.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int BIT = 16;

  logic            clk;
  logic            rst;
  logic [1:0]      tx_start_v;
  logic [1:0][7:0] data_v;
  logic [1:0]      par_v;
  logic [1:0]      par_en_v;
  logic [1:0]      tx_v;
  logic [1:0]      busy_v;
  logic [1:0]      done_v;
  tx_state_t       st0;
  tx_state_t       st1;

  int checks   = 0;
  int failures = 0;

  // Expected frames: [15:12] bit count, [11:0] line values, first bit in [11].
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       par;
    logic       par_en;
    logic [3:0] len;
    logic [11:0] seq;
  } vec_t;
  vec_t vecs[5];

  uart_tx_serializer #(.CLKS_PER_BIT(BIT), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[0]), .data_in(data_v[0]),
    .parity_in(par_v[0]), .parity_en(par_en_v[0]), .tx(tx_v[0]),
    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .fsm_state(st0)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(BIT), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_start(tx_start_v[1]), .data_in(data_v[1]),
    .parity_in(par_v[1]), .parity_en(par_en_v[1]), .tx(tx_v[1]),
    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .fsm_state(st1)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Driver: one-cycle start request, then scramble the frame inputs.
  task automatic send(input int k, input logic [7:0] d, input logic p, input logic pe,
                      input logic [3:0] len, input logic [11:0] seq);
    @(negedge clk);
    data_v[k]     = d;
    par_v[k]      = p;
    par_en_v[k]   = pe;
    tx_start_v[k] = 1'b1;
    if (k == 0) exp_q0.push_back({len, seq});
    else        exp_q1.push_back({len, seq});
    @(negedge clk);
    tx_start_v[k] = 1'b0;
    data_v[k]     = 8'($urandom_range(0, 255));
    par_v[k]      = 1'($urandom_range(0, 1));
    par_en_v[k]   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (done_v[k] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d_done_timeout", k), {31'd0, done_v[k]}, 32'd1);
  endtask

  // Scoreboard monitor: pops an expected frame on each start bit and checks
  // every bit at mid-period plus the exact tx_done cycle.
  task automatic monitor(input int k);
    logic [15:0] e;
    int          len;
    logic [11:0] seq;
    int          qs;
    forever begin
      @(negedge clk);
      if (!rst && tx_v[k] === 1'b0) begin
        qs = (k == 0) ? exp_q0.size() : exp_q1.size();
        check($sformatf("dut%0d_frame_expected", k), (qs > 0) ? 32'd1 : 32'd0, 32'd1);
        if (qs == 0) begin
          while (busy_v[k] === 1'b1 && !rst) @(negedge clk);
        end else begin
          e   = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          len = int'(e[15:12]);
          seq = e[11:0];
          for (int c = 0; c <= len * BIT; c++) begin
            if (c > 0) @(negedge clk);
            if (rst) break;
            if ((c % BIT) == BIT / 2 && (c / BIT) < len)
              check($sformatf("dut%0d_bit%0d", k, c / BIT), {31'd0, tx_v[k]},
                    {31'd0, seq[11 - c / BIT]});
            check($sformatf("dut%0d_done_c%0d", k, c), {31'd0, done_v[k]},
                  (c == len * BIT) ? 32'd1 : 32'd0);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // tx_done and tx_busy must never coincide
  always @(negedge clk) begin
    if (!rst && (done_v != 2'b00)) begin
      check("done_busy_excl", {30'd0, done_v & busy_v}, 32'd0);
    end
  end

  initial begin
    bit bad0;
    bit bad1;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 4'd11, 12'b0101_0010_1010};
    vecs[1] = '{1, 8'hFF, 1'b0, 1'b0, 4'd11, 12'b0111_1111_1110};
    vecs[2] = '{0, 8'h3C, 1'b0, 1'b1, 4'd11, 12'b0001_1110_0010};
    vecs[3] = '{0, 8'h81, 1'b1, 1'b0, 4'd10, 12'b0100_0000_1100};
    vecs[4] = '{1, 8'h5A, 1'b1, 1'b1, 4'd12, 12'b0010_1101_0111};

    rst        = 1'b1;
    tx_start_v = '0;
    data_v     = '0;
    par_v      = '0;
    par_en_v   = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_tx%0d", k),   {31'd0, tx_v[k]},   32'd1);
      check($sformatf("rst_busy%0d", k), {31'd0, busy_v[k]}, 32'd0);
      check($sformatf("rst_done%0d", k), {31'd0, done_v[k]}, 32'd0);
    end
    check("rst_state0", {29'd0, st0}, {29'd0, ST_IDLE});
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle for 100 cycles
    bad0 = 0;
    bad1 = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad0 = 1;
      if (tx_v[1] !== 1'b1 || busy_v[1] !== 1'b0 || done_v[1] !== 1'b0) bad1 = 1;
    end
    check("idle_quiet0", {31'd0, bad0}, 32'd0);
    check("idle_quiet1", {31'd0, bad1}, 32'd0);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].dut, vecs[i].data, vecs[i].par, vecs[i].par_en, vecs[i].len, vecs[i].seq);
      wait_done(vecs[i].dut, 400);
      repeat (5) @(negedge clk);
    end

    // Start request and data change in the middle of DATA are ignored
    send(0, 8'h96, 1'b0, 1'b1, 4'd11, 12'b0011_0100_1010);
    for (int n = 0; n < 100 && st0 != ST_DATA; n++) @(negedge clk);
    repeat (4 * BIT) @(negedge clk);
    tx_start_v[0] = 1'b1;
    data_v[0]     = 8'h00;
    par_v[0]      = 1'b1;
    par_en_v[0]   = 1'b0;
    @(negedge clk);
    tx_start_v[0] = 1'b0;
    wait_done(0, 400);
    repeat (60) @(negedge clk);
    check("mid_no_restart_busy", {31'd0, busy_v[0]}, 32'd0);
    check("mid_no_restart_tx",   {31'd0, tx_v[0]},   32'd1);
    check("mid_queue_empty",     exp_q0.size(),      32'd0);

    // Held start: two back-to-back frames
    @(negedge clk);
    data_v[0]     = 8'h55;
    par_v[0]      = 1'b0;
    par_en_v[0]   = 1'b1;
    tx_start_v[0] = 1'b1;
    exp_q0.push_back({4'd11, 12'b0101_0101_0010});
    exp_q0.push_back({4'd11, 12'b0111_1000_0010});
    @(negedge clk);
    data_v[0] = 8'h0F;
    wait_done(0, 400);
    @(negedge clk);
    check("b2b_start_tx",   {31'd0, tx_v[0]},   32'd0);
    check("b2b_start_busy", {31'd0, busy_v[0]}, 32'd1);
    tx_start_v[0] = 1'b0;
    wait_done(0, 400);
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of the parity bit
    send(0, 8'hE7, 1'b1, 1'b1, 4'd11, 12'b0111_0011_1110);
    for (int n = 0; n < 400 && st0 != ST_PARITY; n++) @(negedge clk);
    check("reached_parity", {29'd0, st0}, {29'd0, ST_PARITY});
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_tx",    {31'd0, tx_v[0]},   32'd1);
    check("arst_busy",  {31'd0, busy_v[0]}, 32'd0);
    check("arst_done",  {31'd0, done_v[0]}, 32'd0);
    check("arst_state", {29'd0, st0},       {29'd0, ST_IDLE});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad0 = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad0 = 1;
    end
    check("post_rst_quiet", {31'd0, bad0}, 32'd0);
    send(0, 8'hC3, 1'b0, 1'b1, 4'd11, 12'b0110_0001_1010);
    wait_done(0, 400);

    repeat (20) @(negedge clk);
    check("final_q0_empty", exp_q0.size(), 32'd0);
    check("final_q1_empty", exp_q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
